// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war player front end:
// move codes, press FSM states and the active-low 7-segment digit table.
package tow_pkg;

    typedef enum logic [2:0] {
        REST  = 3'b100,
        RIGHT = 3'b001,
        LEFT  = 3'b010
    } move_t;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } press_state_t;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
    localparam logic [6:0] SEG_DIGIT [0:7] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000
    };

endpackage

// File: rtl/tow_score_cnt.sv
// Saturating 3-bit round-win counter with a registered 7-segment digit.
// The digit is loaded from the next count so it always matches the count.
module tow_score_cnt
    import tow_pkg::*;
#(
    parameter logic [2:0] SCORE_MAX = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       inc,
    output logic [2:0] score,
    output logic [6:0] hex
);

    logic [2:0] cnt_q, cnt_d;
    logic [6:0] hex_q, hex_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != SCORE_MAX)) begin
            cnt_d = cnt_q + 3'd1;
        end
        hex_d = SEG_DIGIT[cnt_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
            hex_q <= SEG_DIGIT[0];
        end else if (clear) begin
            cnt_q <= 3'd0;
            hex_q <= SEG_DIGIT[0];
        end else begin
            cnt_q <= cnt_d;
            hex_q <= hex_d;
        end
    end

    assign score = cnt_q;
    assign hex   = hex_q;

endmodule

// File: rtl/tow_player_score.sv
// Tug-of-war player front end: key/press edge detection into move codes, per-side
// scores and digits. TOW_SYNC_EN selects a 2-flop key synchronizer instead of one register.
module tow_player_score
    import tow_pkg::*;
#(
    parameter logic [2:0] SCORE_MAX = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       key_l_n,
    input  logic       press_r,
    input  logic       round_end,
    input  logic       winner_l,
    output logic [2:0] move,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic [6:0] hex_l,
    output logic [6:0] hex_r,
    output logic       game_over
);

    logic key_l_s;

`ifdef TOW_SYNC_EN
    // Both stages reset to 1 so a reset never looks like a key press.
    logic [1:0] key_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sync_q <= 2'b11;
        end else if (clear) begin
            key_sync_q <= 2'b11;
        end else begin
            key_sync_q <= {key_sync_q[0], key_l_n};
        end
    end

    assign key_l_s = key_sync_q[1];
`else
    logic key_reg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg_q <= 1'b1;
        end else if (clear) begin
            key_reg_q <= 1'b1;
        end else begin
            key_reg_q <= key_l_n;
        end
    end

    assign key_l_s = key_reg_q;
`endif

    logic         left_in, right_in;
    logic         l_pulse, r_pulse;
    press_state_t l_state_q, l_state_d;
    press_state_t r_state_q, r_state_d;

    assign left_in  = ~key_l_s;
    assign right_in = press_r;

    always_comb begin
        l_state_d = left_in ? HELD : IDLE;
        r_state_d = right_in ? HELD : IDLE;
        l_pulse   = (l_state_q == IDLE) && left_in;
        r_pulse   = (r_state_q == IDLE) && right_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_state_q <= IDLE;
        end else if (clear) begin
            l_state_q <= IDLE;
        end else begin
            l_state_q <= l_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= IDLE;
        end else if (clear) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    // Simultaneous pulses cancel; round end and game over force the rope to rest.
    move_t move_q, move_d;

    always_comb begin
        move_d = REST;
        if (!(round_end || game_over)) begin
            if (l_pulse && !r_pulse) begin
                move_d = LEFT;
            end else if (r_pulse && !l_pulse) begin
                move_d = RIGHT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_q <= REST;
        end else if (clear) begin
            move_q <= REST;
        end else begin
            move_q <= move_d;
        end
    end

    assign move = move_q;

    logic inc_l, inc_r;

    assign game_over = (score_l == SCORE_MAX) || (score_r == SCORE_MAX);
    assign inc_l     = round_end && !game_over && winner_l;
    assign inc_r     = round_end && !game_over && !winner_l;

    tow_score_cnt #(.SCORE_MAX(SCORE_MAX)) u_score_l (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (inc_l),
        .score (score_l),
        .hex   (hex_l)
    );

    tow_score_cnt #(.SCORE_MAX(SCORE_MAX)) u_score_r (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (inc_r),
        .score (score_r),
        .hex   (hex_r)
    );

endmodule

// File: tb/tb_tow_player_score.sv
// Self-checking bench for tow_player_score: directed scenarios plus random play,
// compared every cycle against an edge-detect / score reference model.
module tb_tow_player_score;

    localparam int SMAX = 7;
    localparam logic [2:0] MV_REST  = 3'b100;
    localparam logic [2:0] MV_RIGHT = 3'b001;
    localparam logic [2:0] MV_LEFT  = 3'b010;

`ifdef TOW_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n, clear, key_l_n, press_r, round_end, winner_l;
    logic [2:0] move, score_l, score_r;
    logic [6:0] hex_l, hex_r;
    logic       game_over;

    tow_player_score dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .key_l_n   (key_l_n),
        .press_r   (press_r),
        .round_end (round_end),
        .winner_l  (winner_l),
        .move      (move),
        .score_l   (score_l),
        .score_r   (score_r),
        .hex_l     (hex_l),
        .hex_r     (hex_r),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit         key_hist[$];
    bit         prev_l, prev_r;
    int         m_sl, m_sr;
    logic [2:0] m_move;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b1000000;
            1: seg = 7'b1111001;
            2: seg = 7'b0100100;
            3: seg = 7'b0110000;
            4: seg = 7'b0011001;
            5: seg = 7'b0010010;
            6: seg = 7'b0000010;
            default: seg = 7'b1111000;
        endcase
    endfunction

    task automatic model_reset();
        key_hist.delete();
        for (int i = 0; i < LAT; i++) key_hist.push_back(1'b0);
        prev_l = 1'b0;
        prev_r = 1'b0;
        m_sl   = 0;
        m_sr   = 0;
        m_move = MV_REST;
    endtask

    // One clock edge of the reference: rising edges of the (delayed) press levels.
    task automatic model_edge(input bit kn, input bit pr, input bit re, input bit wl, input bit clr);
        bit lin, lp, rp, over;
        if (clr) begin
            model_reset();
            return;
        end
        lin = key_hist.pop_front();
        key_hist.push_back(!kn);
        lp = lin && !prev_l;
        rp = pr && !prev_r;
        prev_l = lin;
        prev_r = pr;
        over = (m_sl == SMAX) || (m_sr == SMAX);
        if (re || over)      m_move = MV_REST;
        else if (lp && !rp)  m_move = MV_LEFT;
        else if (rp && !lp)  m_move = MV_RIGHT;
        else                 m_move = MV_REST;
        if (re && !over) begin
            if (wl) m_sl = (m_sl < SMAX) ? m_sl + 1 : m_sl;
            else    m_sr = (m_sr < SMAX) ? m_sr + 1 : m_sr;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".move"},  int'(move),      int'(m_move));
        chk({tag, ".sl"},    int'(score_l),   m_sl);
        chk({tag, ".sr"},    int'(score_r),   m_sr);
        chk({tag, ".hexl"},  int'(hex_l),     int'(seg(m_sl)));
        chk({tag, ".hexr"},  int'(hex_r),     int'(seg(m_sr)));
        chk({tag, ".over"},  int'(game_over), int'((m_sl == SMAX) || (m_sr == SMAX)));
    endtask

    task automatic step(input string tag, input bit kn, input bit pr, input bit re,
                        input bit wl, input bit clr);
        @(negedge clk);
        key_l_n   = kn;
        press_r   = pr;
        round_end = re;
        winner_l  = wl;
        clear     = clr;
        @(posedge clk);
        model_edge(kn, pr, re, wl, clr);
        #1;
        check_all(tag);
        $display("%s kn=%0b pr=%0b re=%0b wl=%0b clr=%0b move=%03b sl=%0d sr=%0d over=%0b",
                 tag, kn, pr, re, wl, clr, move, score_l, score_r, game_over);
    endtask

    initial begin
        int n_left, left_at, n_moves;
        rst_n = 1'b0; clear = 1'b0; key_l_n = 1'b1; press_r = 1'b0;
        round_end = 1'b0; winner_l = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Held key: one LEFT at the expected latency, then a second press
        step("idle", 1, 0, 0, 0, 0);
        n_left = 0; left_at = -1;
        for (int j = 0; j < 10; j++) begin
            step("hold", 0, 0, 0, 0, 0);
            if (move === MV_LEFT) begin
                n_left++;
                if (left_at < 0) left_at = j;
            end
        end
        chk("hold.count", n_left, 1);
        chk("hold.lat", left_at, LAT);
        for (int j = 0; j < 4; j++) step("rel", 1, 0, 0, 0, 0);
        n_left = 0;
        for (int j = 0; j < 4; j++) begin
            step("press2", 0, 0, 0, 0, 0);
            if (move === MV_LEFT) n_left++;
        end
        chk("press2.count", n_left, 1);
        for (int j = 0; j < 4; j++) step("rel2", 1, 0, 0, 0, 0);

        // Both pulses on the same edge cancel
        n_moves = 0;
        for (int j = 0; j < 6; j++) begin
            step("cancel", 0, (j >= LAT), 0, 0, 0);
            if (move !== MV_REST) n_moves++;
        end
        chk("cancel.moves", n_moves, 0);
        for (int j = 0; j < 3; j++) step("rel3", 1, 0, 0, 0, 0);

        // Press_r alone gives RIGHT one edge after it is sampled
        step("right", 1, 1, 0, 0, 0);
        chk("right.move", int'(move), int'(MV_RIGHT));
        step("right2", 1, 1, 0, 0, 0);

        // Eight left round wins: saturation and game over
        for (int j = 0; j < 8; j++) begin
            step("win_l", 1, 0, 1, 1, 0);
            step("gap", 1, 0, 0, 0, 0);
        end
        chk("sat.sl", int'(score_l), 7);
        chk("sat.hexl", int'(hex_l), int'(7'b1111000));
        chk("sat.over", int'(game_over), 1);
        n_moves = 0;
        for (int j = 0; j < 5; j++) begin
            step("over_key", (j < 3) ? 1'b0 : 1'b1, (j == 1), (j == 4), 0, 0);
            if (move !== MV_REST) n_moves++;
        end
        chk("over.moves", n_moves, 0);
        chk("over.sr_frozen", int'(score_r), 0);

        // Clear with score_r=3
        step("clr0", 1, 0, 0, 0, 1);
        for (int j = 0; j < 3; j++) step("win_r", 1, 0, 1, 0, 0);
        chk("pre_clr.sr", int'(score_r), 3);
        step("clr", 1, 0, 0, 0, 1);
        chk("clr.sr", int'(score_r), 0);
        chk("clr.hexr", int'(hex_r), int'(7'b1000000));

        // Asynchronous reset mid-run
        step("pre_rst", 1, 0, 1, 1, 0);
        step("pre_rst2", 0, 1, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        key_l_n = 1'b1; press_r = 1'b0; round_end = 1'b0;
        step("post_rst", 1, 0, 0, 0, 0);

        // Random play
        for (int j = 0; j < 400; j++) begin
            step("rand",
                 ($urandom_range(0, 2) != 0) ? key_l_n : ~key_l_n,
                 ($urandom_range(0, 2) != 0) ? press_r : ~press_r,
                 ($urandom_range(0, 7) == 0),
                 1'($urandom),
                 ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
